combo_checker: RTL and testbench
================================

COMBO_CHECKER -- requirements
Module: combo_checker

Interface
Parameters (name, default, meaning):
REQ-001 CODE0, 16'h0012, first combination word loaded at reset.
REQ-002 CODE1, 16'h0034, second combination word loaded at reset.
REQ-003 CODE2, 16'h0056, third combination word loaded at reset.
REQ-004 MAX_FAILS, 3, failed attempts (1..3) that trigger lockout.
REQ-005 LOCKOUT_CYCLES, 100_000_000, lockout duration in clk cycles (>=1).

Ports (name, direction, width, meaning):
REQ-006 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-007 clk  in  1  system clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 entry  in  16  latched switch word from the upstream entry latch.
REQ-010 entry_valid  in  1  one-cycle strobe; entry is valid in that cycle.
REQ-011 lock_cmd  in  1  one-cycle strobe requesting relock or abort.
REQ-012 program_cmd  in  1  one-cycle strobe requesting combination change; honoured only in OPEN.
REQ-013 unlocked  out  1  high while in OPEN.
REQ-014 error  out  1  one-cycle pulse on a failed attempt.
REQ-015 locked_out  out  1  high while in LOCKOUT.
REQ-016 programming  out  1  high in PROG0..PROG2.
REQ-017 stage  out  2  entries accepted in the current attempt or programming sequence (0..2).
REQ-018 fail_count  out  2  consecutive failed attempts.

Function
REQ-019 States SHALL be ENTER0, ENTER1, ENTER2, OPEN, LOCKOUT, PROG0, PROG1, PROG2; all outputs SHALL be registered and update the cycle after the sampled strobe.
REQ-020 ENTER0/1/2 SHALL accept entry_valid, compare entry with stored code 0/1/2, AND the result into a match flag (cleared in ENTER0), and advance; no per-word feedback SHALL be given.
REQ-021 In ENTER2, entry_valid with all three words matching SHALL go to OPEN and clear fail_count.
REQ-022 In ENTER2, entry_valid with any mismatch SHALL pulse error, increment fail_count, and go to ENTER0; if the incremented count equals MAX_FAILS, the block SHALL go to LOCKOUT instead.
REQ-023 lock_cmd in ENTER1/ENTER2 SHALL abort the attempt to ENTER0 without error and without changing fail_count.
REQ-024 LOCKOUT SHALL ignore entry_valid, lock_cmd and program_cmd for exactly LOCKOUT_CYCLES cycles, then clear fail_count and go to ENTER0.
REQ-025 OPEN SHALL ignore entry_valid; lock_cmd SHALL go to ENTER0; program_cmd SHALL go to PROG0.
REQ-026 PROG0/1/2 SHALL capture entry into shadow registers 0/1/2; on the PROG2 entry, all three stored codes SHALL be committed in the same cycle and the block SHALL return to OPEN.
REQ-027 lock_cmd in PROG0..PROG2 SHALL discard the shadow words, leave the stored codes unchanged, and go to ENTER0.
REQ-028 When lock_cmd and entry_valid coincide, lock_cmd SHALL win and the entry SHALL be dropped; when lock_cmd and program_cmd coincide in OPEN, lock_cmd SHALL win.
REQ-029 fail_count SHALL saturate at MAX_FAILS and never wrap.

Reset
REQ-030 reset SHALL force ENTER0, load CODE0..CODE2 into the stored codes, clear the shadow words, match flag, fail_count, stage and the lockout timer, and drive every output to 0; this SHALL apply from any state, including mid-programming and mid-lockout.

Structure
REQ-031 The state enum, code width (16) and default codes SHALL live in the shared package combo_lock_pkg.
REQ-032 The lockout countdown SHALL be the sub-module lockout_timer (start strobe, done pulse, parameter LOCKOUT_CYCLES).

Verification
Bench parameters: MAX_FAILS=3, LOCKOUT_CYCLES=8.
REQ-033 Enter 0012, 0034, 0056 -> unlocked=1 one cycle after the third strobe; error never asserted.
REQ-034 Enter 0012, 0099, 0056 -> one-cycle error pulse, fail_count=1, stage=0, unlocked=0.
REQ-035 Three wrong attempts -> locked_out=1 for exactly 8 cycles; entries during lockout ignored; afterwards fail_count=0 and stage=0.
REQ-036 In OPEN: program_cmd, then enter 1111, 2222, 3333; then lock_cmd; then enter 0012, 0034, 0056 -> error. Then enter 1111, 2222, 3333 -> unlocked=1.
REQ-037 In PROG1, assert lock_cmd and entry_valid in the same cycle -> ENTER0 and codes unchanged; old code still unlocks.
REQ-038 Assert reset in ENTER2 with fail_count=2 -> all outputs 0 the next cycle; default code unlocks.

Source files
------------

// File: rtl/combo_lock_pkg.sv
// Shared types and defaults for the combination checker.
package combo_lock_pkg;

    localparam int CODE_W = 16;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t DEFAULT_CODE0 = 16'h0012;
    localparam code_t DEFAULT_CODE1 = 16'h0034;
    localparam code_t DEFAULT_CODE2 = 16'h0056;

    typedef enum logic [2:0] {
        ENTER0,
        ENTER1,
        ENTER2,
        OPEN,
        LOCKOUT,
        PROG0,
        PROG1,
        PROG2
    } state_e;

endpackage

// File: rtl/lockout_timer.sv
// Countdown for the lockout period: start loads the count, done pulses in the
// last cycle of the period so the FSM leaves LOCKOUT after exactly
// LOCKOUT_CYCLES cycles.
module lockout_timer #(
    parameter int LOCKOUT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int                CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LOAD  = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    assign done = run_q && (cnt_q == '0);

    // Next-count logic: load on start, otherwise count down to zero and stop.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            cnt_d = LOAD;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/combo_checker.sv
// Three-word combination lock with failed-attempt lockout and in-field
// reprogramming of the combination from the OPEN state.
module combo_checker
    import combo_lock_pkg::*;
#(
    parameter code_t CODE0          = DEFAULT_CODE0,
    parameter code_t CODE1          = DEFAULT_CODE1,
    parameter code_t CODE2          = DEFAULT_CODE2,
    parameter int    MAX_FAILS      = 3,
    parameter int    LOCKOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] entry,
    input  logic              entry_valid,
    input  logic              lock_cmd,
    input  logic              program_cmd,
    output logic              unlocked,
    output logic              error,
    output logic              locked_out,
    output logic              programming,
    output logic [1:0]        stage,
    output logic [1:0]        fail_count
);

    state_e     state_q, state_d;
    code_t      code_q   [3];
    code_t      code_d   [3];
    // The third programmed word is committed straight from entry, so only two
    // shadow words need storage.
    code_t      shadow_q [2];
    code_t      shadow_d [2];
    logic       match_q, match_d;
    logic [1:0] fail_q, fail_d, fail_inc;
    logic       error_q, error_d;
    logic       unlocked_q, locked_out_q, programming_q;
    logic [1:0] stage_q, stage_d;
    logic       timer_start, timer_done;

    assign fail_inc    = (fail_q == 2'(MAX_FAILS)) ? fail_q : fail_q + 2'd1;
    assign timer_start = (state_q != LOCKOUT) && (state_d == LOCKOUT);

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk  (clk),
        .reset(reset),
        .start(timer_start),
        .done (timer_done)
    );

    // Next-state, code storage and attempt bookkeeping; lock_cmd always wins.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        match_d  = match_q;
        fail_d   = fail_q;
        error_d  = 1'b0;
        case (state_q)
            ENTER0: begin
                if (!lock_cmd && entry_valid) begin
                    match_d = (entry == code_q[0]);
                    state_d = ENTER1;
                end
            end
            ENTER1, ENTER2: begin
                if (lock_cmd) begin
                    match_d = 1'b0;
                    state_d = ENTER0;
                end else if (entry_valid && state_q == ENTER1) begin
                    match_d = match_q && (entry == code_q[1]);
                    state_d = ENTER2;
                end else if (entry_valid) begin
                    match_d = 1'b0;
                    if (match_q && (entry == code_q[2])) begin
                        fail_d  = 2'd0;
                        state_d = OPEN;
                    end else begin
                        error_d = 1'b1;
                        fail_d  = fail_inc;
                        state_d = (fail_inc == 2'(MAX_FAILS)) ? LOCKOUT : ENTER0;
                    end
                end
            end
            OPEN: begin
                if (lock_cmd) begin
                    state_d = ENTER0;
                end else if (program_cmd) begin
                    state_d = PROG0;
                end
            end
            LOCKOUT: begin
                if (timer_done) begin
                    fail_d  = 2'd0;
                    state_d = ENTER0;
                end
            end
            PROG0, PROG1, PROG2: begin
                if (lock_cmd) begin
                    shadow_d = '{default: '0};
                    state_d  = ENTER0;
                end else if (entry_valid) begin
                    case (state_q)
                        PROG0: begin
                            shadow_d[0] = entry;
                            state_d     = PROG1;
                        end
                        PROG1: begin
                            shadow_d[1] = entry;
                            state_d     = PROG2;
                        end
                        default: begin
                            code_d   = '{shadow_q[0], shadow_q[1], entry};
                            shadow_d = '{default: '0};
                            state_d  = OPEN;
                        end
                    endcase
                end
            end
            default: state_d = ENTER0;
        endcase
    end

    // Stage indicator follows the state being entered.
    always_comb begin
        case (state_d)
            ENTER1, PROG1: stage_d = 2'd1;
            ENTER2, PROG2: stage_d = 2'd2;
            default:       stage_d = 2'd0;
        endcase
    end

    // State, code storage and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ENTER0;
            // NOTE: the code words are a handful of flops that must hold known defaults, so they are reset like any other state.
            code_q        <= '{CODE0, CODE1, CODE2};
            shadow_q      <= '{default: '0};
            match_q       <= 1'b0;
            fail_q        <= 2'd0;
            error_q       <= 1'b0;
            unlocked_q    <= 1'b0;
            locked_out_q  <= 1'b0;
            programming_q <= 1'b0;
            stage_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            shadow_q      <= shadow_d;
            match_q       <= match_d;
            fail_q        <= fail_d;
            error_q       <= error_d;
            unlocked_q    <= (state_d == OPEN);
            locked_out_q  <= (state_d == LOCKOUT);
            programming_q <= (state_d == PROG0) || (state_d == PROG1) || (state_d == PROG2);
            stage_q       <= stage_d;
        end
    end

    assign unlocked    = unlocked_q;
    assign error       = error_q;
    assign locked_out  = locked_out_q;
    assign programming = programming_q;
    assign stage       = stage_q;
    assign fail_count  = fail_q;

endmodule

// File: tb/tb_combo_checker.sv
// Self-checking bench for combo_checker: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_combo_checker;

    localparam int MAX_FAILS = 3;
    localparam int LOCK_CYC  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] entry;
    logic        entry_valid;
    logic        lock_cmd;
    logic        program_cmd;
    logic        unlocked, error, locked_out, programming;
    logic [1:0]  stage, fail_count;

    int n_cmp = 0;
    int n_bad = 0;

    combo_checker #(
        .MAX_FAILS     (MAX_FAILS),
        .LOCKOUT_CYCLES(LOCK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .entry      (entry),
        .entry_valid(entry_valid),
        .lock_cmd   (lock_cmd),
        .program_cmd(program_cmd),
        .unlocked   (unlocked),
        .error      (error),
        .locked_out (locked_out),
        .programming(programming),
        .stage      (stage),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_codes [3];
    logic [15:0] m_attempt [$];
    logic [15:0] m_prog [$];
    bit          m_open, m_in_prog, m_valid;
    int          m_lock_left, m_fails;
    bit          e_error;

    always @(posedge clk) begin
        if (reset) begin
            m_codes     = '{16'h0012, 16'h0034, 16'h0056};
            m_attempt.delete();
            m_prog.delete();
            m_open      = 0;
            m_in_prog   = 0;
            m_lock_left = 0;
            m_fails     = 0;
            e_error     = 0;
            m_valid     = 1;
        end else if (m_valid) begin
            e_error = 0;
            if (m_lock_left > 0) begin
                m_lock_left--;
                if (m_lock_left == 0) m_fails = 0;
            end else if (m_in_prog) begin
                if (lock_cmd) begin
                    m_prog.delete();
                    m_in_prog = 0;
                    m_open    = 0;
                end else if (entry_valid) begin
                    m_prog.push_back(entry);
                    if (m_prog.size() == 3) begin
                        for (int i = 0; i < 3; i++) m_codes[i] = m_prog[i];
                        m_prog.delete();
                        m_in_prog = 0;
                    end
                end
            end else if (m_open) begin
                if (lock_cmd) m_open = 0;
                else if (program_cmd) m_in_prog = 1;
            end else begin
                if (lock_cmd) begin
                    m_attempt.delete();
                end else if (entry_valid) begin
                    m_attempt.push_back(entry);
                    if (m_attempt.size() == 3) begin
                        if (m_attempt[0] == m_codes[0] && m_attempt[1] == m_codes[1] &&
                            m_attempt[2] == m_codes[2]) begin
                            m_open  = 1;
                            m_fails = 0;
                        end else begin
                            e_error = 1;
                            m_fails = (m_fails + 1 > MAX_FAILS) ? MAX_FAILS : m_fails + 1;
                            if (m_fails == MAX_FAILS) m_lock_left = LOCK_CYC;
                        end
                        m_attempt.delete();
                    end
                end
            end
        end
    end

    // Compare process: DUT outputs against the model on every cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            check("unlocked", int'(unlocked), int'(m_open && !m_in_prog));
            check("error", int'(error), int'(e_error));
            check("locked_out", int'(locked_out), int'(m_lock_left > 0));
            check("programming", int'(programming), int'(m_in_prog));
            check("stage", int'(stage), m_in_prog ? m_prog.size() : m_attempt.size());
            check("fail_count", int'(fail_count), m_fails);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        entry_valid = 0; lock_cmd = 0; program_cmd = 0; reset = 0;
    endtask

    task automatic enter(input logic [15:0] w);
        entry = w; entry_valid = 1;
        @(negedge clk);
        idle();
    endtask

    task automatic enter3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        enter(a); enter(b); enter(c);
    endtask

    task automatic do_lock();
        lock_cmd = 1;
        @(negedge clk);
        idle();
    endtask

    task automatic do_prog();
        program_cmd = 1;
        @(negedge clk);
        idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".unlocked"}, int'(unlocked), 0);
        check({tag, ".error"}, int'(error), 0);
        check({tag, ".locked_out"}, int'(locked_out), 0);
        check({tag, ".programming"}, int'(programming), 0);
        check({tag, ".stage"}, int'(stage), 0);
        check({tag, ".fail_count"}, int'(fail_count), 0);
    endtask

    initial begin
        int lock_len;
        logic [15:0] pool [7];
        pool = '{16'h0012, 16'h0034, 16'h0056, 16'h1111, 16'h2222, 16'h3333, 16'hBEEF};

        entry = '0;
        idle();
        reset = 1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 0;

        // Correct default combination opens the lock.
        enter(16'h0012);
        enter(16'h0034);
        check("open.stage_before", int'(stage), 2);
        check("open.unlocked_before", int'(unlocked), 0);
        enter(16'h0056);
        check("open.unlocked", int'(unlocked), 1);
        check("open.error", int'(error), 0);
        do_lock();
        check("relock.unlocked", int'(unlocked), 0);

        // One wrong word anywhere fails the whole attempt.
        enter3(16'h0012, 16'h0099, 16'h0056);
        check("bad.error", int'(error), 1);
        check("bad.fail_count", int'(fail_count), 1);
        check("bad.stage", int'(stage), 0);
        check("bad.unlocked", int'(unlocked), 0);
        @(negedge clk);
        check("bad.error_pulse_width", int'(error), 0);

        // Two more failures trigger lockout for exactly LOCK_CYC cycles.
        enter3(16'h0000, 16'h0034, 16'h0056);
        check("fail2.count", int'(fail_count), 2);
        enter3(16'h0012, 16'h0034, 16'h0057);
        check("lock.error", int'(error), 1);
        check("lock.locked_out", int'(locked_out), 1);
        lock_len = 1;
        for (int i = 0; i < 3 * LOCK_CYC; i++) begin
            entry = pool[i % 3]; entry_valid = 1;
            lock_cmd = (i == 4); program_cmd = (i == 5);
            @(negedge clk);
            if (!locked_out) break;
            lock_len++;
        end
        idle();
        check("lock.duration", lock_len, LOCK_CYC);
        check("lock.after_fail_count", int'(fail_count), 0);
        check("lock.after_stage", int'(stage), 0);
        check("lock.after_unlocked", int'(unlocked), 0);

        // Reprogram the combination, then the old code fails and the new opens.
        enter3(16'h0012, 16'h0034, 16'h0056);
        do_prog();
        check("prog.programming", int'(programming), 1);
        check("prog.unlocked", int'(unlocked), 0);
        enter3(16'h1111, 16'h2222, 16'h3333);
        check("prog.done_unlocked", int'(unlocked), 1);
        check("prog.done_programming", int'(programming), 0);
        do_lock();
        enter3(16'h0012, 16'h0034, 16'h0056);
        check("prog.old_code_error", int'(error), 1);
        enter3(16'h1111, 16'h2222, 16'h3333);
        check("prog.new_code_unlocked", int'(unlocked), 1);
        check("prog.new_code_fail_clear", int'(fail_count), 0);

        // Abort programming in PROG1 with lock and entry together.
        do_prog();
        enter(16'h4444);
        check("abort.stage", int'(stage), 1);
        entry = 16'h5555; entry_valid = 1; lock_cmd = 1;
        @(negedge clk);
        idle();
        check("abort.programming", int'(programming), 0);
        check("abort.unlocked", int'(unlocked), 0);
        check("abort.stage0", int'(stage), 0);
        enter3(16'h1111, 16'h2222, 16'h3333);
        check("abort.old_code_unlocked", int'(unlocked), 1);
        do_lock();

        // Reset mid-attempt with two failures restores defaults.
        enter3(16'h0001, 16'h0002, 16'h0003);
        enter3(16'h0001, 16'h0002, 16'h0003);
        enter(16'h0012);
        enter(16'h0034);
        check("rst.fail_count_before", int'(fail_count), 2);
        check("rst.stage_before", int'(stage), 2);
        reset = 1;
        @(negedge clk);
        check_all_zero("rst");
        idle();
        enter3(16'h0012, 16'h0034, 16'h0056);
        check("rst.default_unlocks", int'(unlocked), 1);

        // Randomized traffic, checked every cycle by the model comparison.
        for (int i = 0; i < 4000; i++) begin
            int sz;
            sz          = m_in_prog ? 0 : m_attempt.size();
            reset       = ($urandom_range(0, 299) == 0);
            lock_cmd    = ($urandom_range(0, 9) == 0);
            program_cmd = ($urandom_range(0, 3) == 0);
            entry_valid = ($urandom_range(0, 1) == 0);
            if (!m_in_prog && sz < 3 && $urandom_range(0, 3) != 0)
                entry = m_codes[sz];
            else if ($urandom_range(0, 3) == 0)
                entry = 16'($urandom);
            else
                entry = pool[$urandom_range(0, 6)];
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
